cci_error_kill_ctrl: RTL and testbench
======================================

Name: cci_error_kill_ctrl

Overview:
- Sits directly downstream of the CCI X/Z rule checker and consumes its four per-channel error flags and timestamps.
- Detects the first protocol error and records which channel(s) failed and when.
- Allows a bounded drain window so in-flight transactions still get logged, then requests a simulation kill through a req/ack handshake with the ASE kill process.

Parameters:
- TIMESLOT_WIDTH, 32: width of timestamp inputs and err_time.
- DRAIN_CYCLES, 16: number of clocks to wait after first error before requesting kill (0 legal).
- CNT_WIDTH, 16: width of err_count.

Ports:
- clk  input  1  system clock, all logic posedge.
- resetb  input  1  synchronous, active-low reset.
- enable  input  1  arms capture of a first error while in IDLE.
- tx_ch0_error  input  1  checker error level, TX channel 0.
- tx_ch1_error  input  1  checker error level, TX channel 1.
- rx_ch0_error  input  1  checker error level, RX channel 0.
- rx_ch1_error  input  1  checker error level, RX channel 1.
- tx_ch0_time, tx_ch1_time, rx_ch0_time, rx_ch1_time  input  TIMESLOT_WIDTH each  checker timestamps.
- kill_ack  input  1  kill process acknowledge.
- kill_req  output  1  kill request, held until acked.
- err_valid  output  1  first error captured; sticky until reset.
- err_mask  output  4  accumulated channels seen: bit0 tx0, bit1 tx1, bit2 rx0, bit3 rx1.
- err_first_chan  output  2  encoded channel of first error: 0 tx0, 1 tx1, 2 rx0, 3 rx1.
- err_time  output  TIMESLOT_WIDTH  timestamp of first error.
- err_count  output  CNT_WIDTH  saturating count of channel rising edges since capture.
- busy  output  1  high in DRAIN or KILL.

Behaviour:
- Reset (resetb=0 at posedge):
  - State=IDLE; kill_req, err_valid, busy=0.
  - err_mask, err_first_chan, err_time, err_count, drain counter=0.
  - Edge-detect history registers=0.
  - Reset overrides every state, including mid-KILL: kill_req drops the cycle after reset is sampled.
- Edge detect:
  - rise[i] = err_in[i] & ~prev[i]; prev[i] is updated every clock.
  - A level already high on the first post-reset cycle counts as a rise.
  - Checker flags are levels that stay high, so only rises are counted.
- IDLE:
  - If enable=1 and any rise: capture, then go to DRAIN.
  - Capture sets err_valid=1, err_mask=rise, and loads the drain counter with DRAIN_CYCLES.
  - Capture sets err_count=popcount(rise).
  - Capture sets err_first_chan/err_time from the highest-priority rising channel. Priority: tx0 > tx1 > rx0 > rx1.
  - enable=0: rises are ignored, but prev still updates, so a level that stays high is not captured later.
- DRAIN:
  - busy=1.
  - err_mask |= rise; err_count += popcount(rise), saturating at all-ones.
  - If counter==0, go to KILL; otherwise decrement.
  - DRAIN lasts DRAIN_CYCLES+1 clocks.
  - enable is ignored once out of IDLE.
- KILL:
  - kill_req=1, busy=1; mask/count accumulation continues.
  - On posedge with kill_ack=1: go to DONE and clear kill_req next cycle.
  - kill_ack outside KILL is ignored.
- DONE:
  - kill_req=0, busy=0; err_valid and captured fields hold.
  - err_mask/err_count keep accumulating.
  - Exit only via reset.
- Latency:
  - err_valid rises 1 clock after the rise is sampled.
  - kill_req rises exactly DRAIN_CYCLES+1 clocks after err_valid.
- Width rules:
  - popcount is 3 bits, zero-extended into CNT_WIDTH.
  - Saturation: if the sum overflows, err_count=all-ones.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset, enable=1, tx_ch1_error rises at cycle 5 with tx_ch1_time=0x64 -> err_valid at 6, err_first_chan=1, err_time=0x64, err_mask=4'b0010, err_count=1, kill_req at cycle 23 (DRAIN_CYCLES=16).
- Simultaneous rise of rx_ch1 and tx_ch0 (times 0x20, 0x30) -> err_first_chan=0, err_time=0x30, err_mask=4'b1001, err_count=2.
- rx_ch0 rises at DRAIN cycle 3 after a tx0 capture -> err_mask=4'b0101, err_count=2, err_first_chan unchanged=0.
- kill_ack held 0 for 10 cycles in KILL, then 1 -> kill_req stays high the whole time, falls the cycle after ack; busy=0; state DONE persists; a subsequent kill_ack has no effect.
- enable=0 while tx_ch0_error rises and stays high, then enable=1 -> no capture, err_valid=0 (no new rise). A later rx_ch1 rise is captured with err_first_chan=3.
- DRAIN_CYCLES=0, CNT_WIDTH=2: kill_req asserted 1 clock after err_valid. Five further rises -> err_count saturates at 3. resetb=0 during KILL -> kill_req=0 and all outputs zero next cycle.

Source files
------------

// File: rtl/cci_error_kill_ctrl.sv
// rtl/cci_error_kill_ctrl.sv - first-error capture, drain window and kill handshake for the CCI checker
module cci_error_kill_ctrl #(
  parameter int TIMESLOT_WIDTH = 32,
  parameter int DRAIN_CYCLES   = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      enable,
  input  logic                      tx_ch0_error,
  input  logic                      tx_ch1_error,
  input  logic                      rx_ch0_error,
  input  logic                      rx_ch1_error,
  input  logic [TIMESLOT_WIDTH-1:0] tx_ch0_time,
  input  logic [TIMESLOT_WIDTH-1:0] tx_ch1_time,
  input  logic [TIMESLOT_WIDTH-1:0] rx_ch0_time,
  input  logic [TIMESLOT_WIDTH-1:0] rx_ch1_time,
  input  logic                      kill_ack,
  output logic                      kill_req,
  output logic                      err_valid,
  output logic [3:0]                err_mask,
  output logic [1:0]                err_first_chan,
  output logic [TIMESLOT_WIDTH-1:0] err_time,
  output logic [CNT_WIDTH-1:0]      err_count,
  output logic                      busy
);

  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  // Sum is wide enough for both the count and a full 3-bit popcount, plus a carry.
  localparam int SW = ((CNT_WIDTH > 3) ? CNT_WIDTH : 3) + 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [SW-1:0] CNT_MAX    = SW'({CNT_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_KILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                prev_q, prev_d;
  logic [DW-1:0]             drain_q, drain_d;
  logic                      kill_req_q, kill_req_d;
  logic                      err_valid_q, err_valid_d;
  logic [3:0]                err_mask_q, err_mask_d;
  logic [1:0]                err_first_q, err_first_d;
  logic [TIMESLOT_WIDTH-1:0] err_time_q, err_time_d;
  logic [CNT_WIDTH-1:0]      err_count_q, err_count_d;
  logic                      busy_q, busy_d;

  logic [3:0] err_in;
  logic [3:0] rise;
  logic [2:0] rise_cnt;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                   input logic [2:0]           inc);
    logic [SW-1:0] sum;
    sum = SW'(base) + SW'(inc);
    if (sum > CNT_MAX) return '1;
    return sum[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    err_in   = {rx_ch1_error, rx_ch0_error, tx_ch1_error, tx_ch0_error};
    rise     = err_in & ~prev_q;
    rise_cnt = popcount4(rise);

    state_d     = state_q;
    prev_d      = err_in;
    drain_d     = drain_q;
    kill_req_d  = kill_req_q;
    err_valid_d = err_valid_q;
    err_mask_d  = err_mask_q;
    err_first_d = err_first_q;
    err_time_d  = err_time_q;
    err_count_d = err_count_q;
    busy_d      = busy_q;

    // Once a first error is held, every later rise is still logged, in any state.
    if (state_q != ST_IDLE) begin
      err_mask_d  = err_mask_q | rise;
      err_count_d = sat_add(err_count_q, rise_cnt);
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && (rise != 4'b0000)) begin
          state_d     = ST_DRAIN;
          err_valid_d = 1'b1;
          err_mask_d  = rise;
          err_count_d = sat_add('0, rise_cnt);
          drain_d     = DRAIN_LOAD;
          busy_d      = 1'b1;
          if (rise[0]) begin
            err_first_d = 2'd0;
            err_time_d  = tx_ch0_time;
          end else if (rise[1]) begin
            err_first_d = 2'd1;
            err_time_d  = tx_ch1_time;
          end else if (rise[2]) begin
            err_first_d = 2'd2;
            err_time_d  = rx_ch0_time;
          end else begin
            err_first_d = 2'd3;
            err_time_d  = rx_ch1_time;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d    = ST_KILL;
          kill_req_d = 1'b1;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_KILL: begin
        if (kill_ack) begin
          state_d    = ST_DONE;
          kill_req_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      drain_q     <= '0;
      kill_req_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_mask_q  <= '0;
      err_first_q <= '0;
      err_time_q  <= '0;
      err_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      drain_q     <= drain_d;
      kill_req_q  <= kill_req_d;
      err_valid_q <= err_valid_d;
      err_mask_q  <= err_mask_d;
      err_first_q <= err_first_d;
      err_time_q  <= err_time_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
    end
  end

  assign kill_req       = kill_req_q;
  assign err_valid      = err_valid_q;
  assign err_mask       = err_mask_q;
  assign err_first_chan = err_first_q;
  assign err_time       = err_time_q;
  assign err_count      = err_count_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_cci_error_kill_ctrl.sv
// tb/tb_cci_error_kill_ctrl.sv - directed bench for cci_error_kill_ctrl (default and DRAIN=0/CNT=2 builds)
module tb_cci_error_kill_ctrl;

  logic clk;
  logic [31:0] t_tx0, t_tx1, t_rx0, t_rx1;

  logic        rstb_a, en_a, ack_a;
  logic [3:0]  err_a;
  logic        kreq_a, val_a, busy_a;
  logic [3:0]  mask_a;
  logic [1:0]  first_a;
  logic [31:0] time_a;
  logic [15:0] cnt_a;

  logic        rstb_b, en_b, ack_b;
  logic [3:0]  err_b;
  logic        kreq_b, val_b, busy_b;
  logic [3:0]  mask_b;
  logic [1:0]  first_b;
  logic [31:0] time_b;
  logic [1:0]  cnt_b;

  int vectors;
  int miscompares;

  cci_error_kill_ctrl #(.TIMESLOT_WIDTH(32), .DRAIN_CYCLES(16), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .resetb(rstb_a), .enable(en_a),
    .tx_ch0_error(err_a[0]), .tx_ch1_error(err_a[1]),
    .rx_ch0_error(err_a[2]), .rx_ch1_error(err_a[3]),
    .tx_ch0_time(t_tx0), .tx_ch1_time(t_tx1), .rx_ch0_time(t_rx0), .rx_ch1_time(t_rx1),
    .kill_ack(ack_a), .kill_req(kreq_a), .err_valid(val_a), .err_mask(mask_a),
    .err_first_chan(first_a), .err_time(time_a), .err_count(cnt_a), .busy(busy_a)
  );

  cci_error_kill_ctrl #(.TIMESLOT_WIDTH(32), .DRAIN_CYCLES(0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .resetb(rstb_b), .enable(en_b),
    .tx_ch0_error(err_b[0]), .tx_ch1_error(err_b[1]),
    .rx_ch0_error(err_b[2]), .rx_ch1_error(err_b[3]),
    .tx_ch0_time(t_tx0), .tx_ch1_time(t_tx1), .rx_ch0_time(t_rx0), .rx_ch1_time(t_rx1),
    .kill_ack(ack_b), .kill_req(kreq_b), .err_valid(val_b), .err_mask(mask_b),
    .err_first_chan(first_b), .err_time(time_b), .err_count(cnt_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_a();
    rstb_a = 1'b0;
    step();
    step();
    rstb_a = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    t_tx0 = 32'h0; t_tx1 = 32'h0; t_rx0 = 32'h0; t_rx1 = 32'h0;
    rstb_a = 1'b0; en_a = 1'b0; ack_a = 1'b0; err_a = 4'b0000;
    rstb_b = 1'b0; en_b = 1'b0; ack_b = 1'b0; err_b = 4'b0000;

    // Single tx1 error, full drain, slow acknowledge, DONE behaviour
    reset_a();
    chk("rst_valid", 64'(val_a), 64'h0);
    chk("rst_kreq", 64'(kreq_a), 64'h0);
    chk("rst_busy", 64'(busy_a), 64'h0);
    chk("rst_mask", 64'(mask_a), 64'h0);
    chk("rst_count", 64'(cnt_a), 64'h0);
    chk("rst_time", 64'(time_a), 64'h0);
    en_a = 1'b1;
    t_tx1 = 32'h64;
    err_a = 4'b0010;
    step();
    chk("t1_valid", 64'(val_a), 64'h1);
    chk("t1_first", 64'(first_a), 64'h1);
    chk("t1_time", 64'(time_a), 64'h64);
    chk("t1_mask", 64'(mask_a), 64'h2);
    chk("t1_count", 64'(cnt_a), 64'h1);
    chk("t1_busy", 64'(busy_a), 64'h1);
    chk("t1_kreq_early", 64'(kreq_a), 64'h0);
    for (int i = 0; i < 16; i++) step();
    chk("t1_kreq_drain16", 64'(kreq_a), 64'h0);
    step();
    chk("t1_kreq_drain17", 64'(kreq_a), 64'h1);
    chk("t1_count_level", 64'(cnt_a), 64'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_kreq_hold", 64'(kreq_a), 64'h1);
    end
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    chk("t4_kreq_drop", 64'(kreq_a), 64'h0);
    chk("t4_busy_done", 64'(busy_a), 64'h0);
    step();
    step();
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    chk("t4_ack_ignored", 64'(kreq_a), 64'h0);
    chk("t4_busy_ignored", 64'(busy_a), 64'h0);
    chk("t4_valid_hold", 64'(val_a), 64'h1);
    chk("t4_time_hold", 64'(time_a), 64'h64);
    t_rx1 = 32'h99;
    err_a = 4'b1010;
    step();
    chk("t4_done_mask", 64'(mask_a), 64'hA);
    chk("t4_done_count", 64'(cnt_a), 64'h2);
    chk("t4_done_first", 64'(first_a), 64'h1);
    chk("t4_done_kreq", 64'(kreq_a), 64'h0);

    // Simultaneous rx1 and tx0 rise: tx0 wins priority
    err_a = 4'b0000;
    reset_a();
    t_rx1 = 32'h20;
    t_tx0 = 32'h30;
    err_a = 4'b1001;
    step();
    chk("t2_first", 64'(first_a), 64'h0);
    chk("t2_time", 64'(time_a), 64'h30);
    chk("t2_mask", 64'(mask_a), 64'h9);
    chk("t2_count", 64'(cnt_a), 64'h2);

    // rx0 joins during the drain window after a tx0 capture
    err_a = 4'b0000;
    reset_a();
    t_tx0 = 32'h11;
    err_a = 4'b0001;
    step();
    chk("t3_first_cap", 64'(first_a), 64'h0);
    step();
    step();
    err_a = 4'b0101;
    step();
    chk("t3_mask", 64'(mask_a), 64'h5);
    chk("t3_count", 64'(cnt_a), 64'h2);
    chk("t3_first", 64'(first_a), 64'h0);
    chk("t3_time", 64'(time_a), 64'h11);
    chk("t3_busy", 64'(busy_a), 64'h1);

    // Rise while disabled is lost; a later rx1 rise is captured
    err_a = 4'b0000;
    en_a = 1'b0;
    reset_a();
    err_a = 4'b0001;
    step();
    step();
    chk("t5_no_cap_dis", 64'(val_a), 64'h0);
    en_a = 1'b1;
    step();
    step();
    chk("t5_no_cap_en", 64'(val_a), 64'h0);
    chk("t5_busy_idle", 64'(busy_a), 64'h0);
    t_rx1 = 32'h77;
    err_a = 4'b1001;
    step();
    chk("t5_valid", 64'(val_a), 64'h1);
    chk("t5_first", 64'(first_a), 64'h3);
    chk("t5_time", 64'(time_a), 64'h77);
    chk("t5_mask", 64'(mask_a), 64'h8);
    chk("t5_count", 64'(cnt_a), 64'h1);

    // Zero drain window, 2-bit saturating count, reset while in KILL
    step();
    rstb_b = 1'b1;
    en_b = 1'b1;
    t_tx0 = 32'h5;
    err_b = 4'b0001;
    step();
    chk("t6_valid", 64'(val_b), 64'h1);
    chk("t6_kreq_early", 64'(kreq_b), 64'h0);
    chk("t6_count1", 64'(cnt_b), 64'h1);
    step();
    chk("t6_kreq", 64'(kreq_b), 64'h1);
    chk("t6_busy", 64'(busy_b), 64'h1);
    err_b = 4'b0011;
    step();
    chk("t6_count2", 64'(cnt_b), 64'h2);
    err_b = 4'b0111;
    step();
    chk("t6_count3", 64'(cnt_b), 64'h3);
    err_b = 4'b1111;
    step();
    err_b = 4'b1110;
    step();
    err_b = 4'b1111;
    step();
    err_b = 4'b1101;
    step();
    err_b = 4'b1111;
    step();
    chk("t6_count_sat", 64'(cnt_b), 64'h3);
    chk("t6_mask", 64'(mask_b), 64'hF);
    chk("t6_kreq_hold", 64'(kreq_b), 64'h1);
    rstb_b = 1'b0;
    step();
    chk("t6_rst_kreq", 64'(kreq_b), 64'h0);
    chk("t6_rst_valid", 64'(val_b), 64'h0);
    chk("t6_rst_busy", 64'(busy_b), 64'h0);
    chk("t6_rst_mask", 64'(mask_b), 64'h0);
    chk("t6_rst_count", 64'(cnt_b), 64'h0);
    chk("t6_rst_time", 64'(time_b), 64'h0);
    chk("t6_rst_first", 64'(first_b), 64'h0);

    // Levels high on the first post-reset cycle count as four rises
    t_tx0 = 32'hAB;
    rstb_b = 1'b1;
    step();
    chk("t7_first", 64'(first_b), 64'h0);
    chk("t7_time", 64'(time_b), 64'hAB);
    chk("t7_mask", 64'(mask_b), 64'hF);
    chk("t7_count_sat", 64'(cnt_b), 64'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
